// File: rtl/sti_unpack.sv
// sti_unpack: unpacks a 1-bpp 128x128 stimulus ROM image into a byte-per-pixel result RAM.
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous, active-low reset
//   start     : one-cycle run request, honoured only while idle
//   sti_rd    : stimulus ROM read strobe
//   sti_addr  : stimulus ROM word address (0..1023)
//   sti_di    : stimulus ROM data, valid in the cycle after sti_rd
//   res_wr    : result RAM write strobe
//   res_addr  : result RAM byte address (0..16383)
//   res_do    : result RAM write data
//   busy      : run in progress
//   done      : last byte written, held until the next accepted start
//   obj_cnt   : number of OBJ_VAL bytes written in the current run
module sti_unpack #(
    parameter logic [7:0] OBJ_VAL    = 8'h01,
    parameter logic       BORDER_CLR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        sti_rd,
    output logic [9:0]  sti_addr,
    input  logic [15:0] sti_di,
    output logic        res_wr,
    output logic [13:0] res_addr,
    output logic [7:0]  res_do,
    output logic        busy,
    output logic        done,
    output logic [14:0] obj_cnt
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] LAT  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [9:0]  w_q, w_d;
    logic [3:0]  b_q, b_d;
    logic [15:0] sr_q, sr_d;
    logic        sti_rd_q, sti_rd_d;
    logic [9:0]  sti_addr_q, sti_addr_d;
    logic        res_wr_q, res_wr_d;
    logic [13:0] res_addr_q, res_addr_d;
    logic [7:0]  res_do_q, res_do_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [14:0] obj_cnt_q, obj_cnt_d;

    logic        pix_en;
    logic        pix_bit;
    logic [13:0] pix_addr;
    logic        pix_border;
    logic        pix_obj;

    // Outputs are registered, so each write is prepared one cycle ahead:
    // LAT prepares pixel 0 straight from sti_di, and each WR cycle with
    // b=1..15 prepares pixel b from the shift register. The WR cycle in
    // which b has wrapped to 0 is the 16th write of the word.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        b_d        = b_q;
        sr_d       = sr_q;
        sti_rd_d   = 1'b0;
        sti_addr_d = sti_addr_q;
        res_wr_d   = 1'b0;
        res_addr_d = res_addr_q;
        res_do_d   = res_do_q;
        busy_d     = busy_q;
        done_d     = done_q;
        obj_cnt_d  = obj_cnt_q;
        pix_en     = 1'b0;
        pix_bit    = 1'b0;
        pix_addr   = {w_q, b_q};
        case (state_q)
            IDLE: if (start) begin
                state_d    = RD;
                w_d        = 10'd0;
                obj_cnt_d  = 15'd0;
                done_d     = 1'b0;
                busy_d     = 1'b1;
                sti_rd_d   = 1'b1;
                sti_addr_d = 10'd0;
            end
            RD: state_d = LAT;
            LAT: begin
                state_d  = WR;
                sr_d     = {sti_di[14:0], 1'b0};
                b_d      = 4'd1;
                pix_en   = 1'b1;
                pix_bit  = sti_di[15];
                pix_addr = {w_q, 4'd0};
            end
            WR: if (b_q != 4'd0) begin
                pix_en  = 1'b1;
                pix_bit = sr_q[15];
                sr_d    = {sr_q[14:0], 1'b0};
                b_d     = b_q + 4'd1;
            end else if (w_q == 10'd1023) begin
                state_d = FIN;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d    = RD;
                w_d        = w_q + 10'd1;
                sti_rd_d   = 1'b1;
                sti_addr_d = w_q + 10'd1;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Border: row (addr[13:7]) or column (addr[6:0]) is 0 or 127.
        pix_border = BORDER_CLR && ((pix_addr[13:7] == 7'd0) || (&pix_addr[13:7]) ||
                                    (pix_addr[6:0] == 7'd0) || (&pix_addr[6:0]));
        pix_obj    = pix_bit && !pix_border;
        if (pix_en) begin
            res_wr_d   = 1'b1;
            res_addr_d = pix_addr;
            res_do_d   = pix_obj ? OBJ_VAL : 8'h00;
            obj_cnt_d  = obj_cnt_q + {14'd0, pix_obj};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            w_q        <= 10'd0;
            b_q        <= 4'd0;
            sr_q       <= 16'd0;
            sti_rd_q   <= 1'b0;
            sti_addr_q <= 10'd0;
            res_wr_q   <= 1'b0;
            res_addr_q <= 14'd0;
            res_do_q   <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            obj_cnt_q  <= 15'd0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            b_q        <= b_d;
            sr_q       <= sr_d;
            sti_rd_q   <= sti_rd_d;
            sti_addr_q <= sti_addr_d;
            res_wr_q   <= res_wr_d;
            res_addr_q <= res_addr_d;
            res_do_q   <= res_do_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            obj_cnt_q  <= obj_cnt_d;
        end
    end

    assign sti_rd   = sti_rd_q;
    assign sti_addr = sti_addr_q;
    assign res_wr   = res_wr_q;
    assign res_addr = res_addr_q;
    assign res_do   = res_do_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign obj_cnt  = obj_cnt_q;
endmodule

// File: doc/sti_unpack.md
STI_UNPACK -- requirements
Module: sti_unpack

Interface
REQ-001 OBJ_VAL, 8'h01, byte written to res RAM for an object pixel (stimulus bit = 1).
REQ-002 BORDER_CLR, 1, when 1 pixels in row 0, row 127, column 0 and column 127 are written as 8'h00 regardless of the stimulus bit.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to unpack the full 128x128 image; sampled only in IDLE.
REQ-006 sti_rd  output  1  stimulus ROM read strobe.
REQ-007 sti_addr  output  10  stimulus ROM word address, 0..1023.
REQ-008 sti_di  input  16  stimulus ROM data; registered by the ROM on the falling edge of the cycle in which sti_rd=1.
REQ-009 res_wr  output  1  result RAM write strobe; the RAM writes on the next rising edge.
REQ-010 res_addr  output  14  result RAM byte address, 0..16383.
REQ-011 res_do  output  8  result RAM write data.
REQ-012 busy  output  1  high from the cycle after an accepted start until done rises.
REQ-013 done  output  1  high level after the last byte is written; held until the next accepted start or reset.
REQ-014 obj_cnt  output  15  count of bytes written as OBJ_VAL in the current run, 0..16384.

Function
REQ-015 Pixel mapping: pixel p = sti_addr*16 + i, with i = 0 taken from sti_di[15] (MSB first); row = p[13:7], col = p[6:0]; res_addr = p.
REQ-016 FSM states: IDLE, RD, LAT, WR, FIN.
REQ-017 IDLE: start=1 -> RD, word counter w=0, obj_cnt cleared, done cleared; start=0 -> stay.
REQ-018 RD (1 cycle): sti_rd=1, sti_addr=w -> LAT.
REQ-019 LAT (1 cycle): sti_rd=0; capture sti_di into a 16-bit shift register; bit counter b=0 -> WR.
REQ-020 WR (16 cycles): res_wr=1, res_addr=w*16+b, res_do=OBJ_VAL if the current MSB of the shift register is 1 and the pixel is not a cleared border pixel, else 8'h00; shift left by 1; b increments.
REQ-021 WR with b=15: w=1023 -> FIN, else w increments -> RD.
REQ-022 FIN (1 cycle): res_wr=0, busy=0, done=1 -> IDLE.
REQ-023 Each word takes 18 cycles; a full run takes 18432 cycles from the first RD to FIN.
REQ-024 obj_cnt increments by 1 in each WR cycle whose res_do equals OBJ_VAL; 15-bit width, so it does not saturate or wrap.
REQ-025 w and b are 10-bit and 4-bit; wrap from 1023 and from 15 is never used as a live address.
REQ-026 start asserted while busy is ignored; no restart and no counter change.
REQ-027 start asserted in the same cycle that FIN completes is ignored; start is sampled only in IDLE.
REQ-028 All outputs are registered; res_wr, res_addr and res_do change together on the same rising edge.
REQ-029 Outside WR, res_wr=0 and res_addr/res_do hold their last values; outside RD, sti_rd=0.
REQ-030 No write is issued to any address more than once per run, and every address 0..16383 is written exactly once.

Reset
REQ-031 When reset=0: state=IDLE; sti_rd=0, sti_addr=0, res_wr=0, res_addr=0, res_do=0, busy=0, done=0, obj_cnt=0, and all counters and the shift register are 0.
REQ-032 Reset mid-run aborts the run immediately; no further res_wr occurs; RAM contents already written are left unchanged.
REQ-033 After reset is released, the block waits in IDLE for a new start.

Verification
REQ-034 All-zero ROM, start pulse -> 16384 writes of 8'h00; done rises 18433 cycles after start; obj_cnt=0.
REQ-035 ROM word 8 = 16'h8001, all other words 0, BORDER_CLR=1 -> res[128]=00 (col 0, cleared), res[143]=01; obj_cnt=1.
REQ-036 Same stimulus with BORDER_CLR=0 -> res[128]=01, res[143]=01; obj_cnt=2.
REQ-037 All-ones ROM, BORDER_CLR=1 -> interior bytes = 01, border bytes = 00; obj_cnt=15876 (126*126).
REQ-038 Second start pulse during the 5000th cycle of a run -> ignored; the total write count is still 16384 and done timing is unchanged.
REQ-039 reset=0 during word 300 -> all outputs 0 within the same cycle, no further writes; a new start then produces a complete correct run.
